// File: rtl/sd_pkg.sv
// Shared types and constants for the sd_access client side: arbiter FSM states
// and the sector address width every sd_access client agrees on.
package sd_pkg;

  localparam int SECTOR_ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ISSUE,
    WAIT,
    RETRY,
    RESP,
    GAP
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping
// around, so the requester just served goes to the back of the line.
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] id
);

  // Scan from the far end so the candidate closest to ptr is written last and wins.
  always_comb begin
    int idx;
    idx   = 0;
    valid = 1'b0;
    id    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx[W-1:0]]) begin
        valid = 1'b1;
        id    = W'(idx);
      end
    end
  end

endmodule

// File: rtl/sd_read_arbiter.sv
// Shares one sd_access sector-read engine among NUM_REQ clients: round-robin grant,
// one start pulse per attempt, timeout and retry, one-cycle done/error back to the client.
module sd_read_arbiter
  import sd_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRIES    = 2,
  parameter int GAP_CYCLES     = 4,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_in,
  input  logic [SECTOR_ADDR_W*NUM_REQ-1:0]   addr_in,
  output logic [NUM_REQ-1:0]                 ack_out,
  output logic [NUM_REQ-1:0]                 done_out,
  output logic [NUM_REQ-1:0]                 error_out,
  output logic                               busy_out,
  output logic [ID_W-1:0]                    grant_id_out,
  output logic [SECTOR_ADDR_W-1:0]           sd_addr_out,
  output logic                               sd_read_en_out,
  input  logic                               sd_done_in,
  input  logic                               sd_error_in
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int GP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  arb_state_t      state, state_nxt;
  logic [ID_W-1:0] ptr;
  logic [TO_W-1:0] tmo_cnt;
  logic [RC_W-1:0] retry_cnt;
  logic [GP_W-1:0] gap_cnt;
  logic            retry_pend;

  logic            pick_valid;
  logic [ID_W-1:0] pick_id;
  logic            fail;
  logic            retry_left;
  logic            gap_last;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_pick (
    .req   (req_in),
    .ptr   (ptr),
    .valid (pick_valid),
    .id    (pick_id)
  );

  // Error beats done in the same cycle; timeout counts as an error.
  assign fail       = sd_error_in || (tmo_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign retry_left = int'(retry_cnt) < MAX_RETRIES;
  assign gap_last   = int'(gap_cnt) >= GAP_CYCLES - 1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pick_valid) state_nxt = GRANT;
      GRANT: state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (fail)            state_nxt = retry_left ? RETRY : RESP;
        else if (sd_done_in) state_nxt = RESP;
      end
      RETRY: state_nxt = GAP;
      RESP:  state_nxt = GAP;
      GAP:   if (gap_last) state_nxt = retry_pend ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      tmo_cnt        <= '0;
      retry_cnt      <= '0;
      gap_cnt        <= '0;
      retry_pend     <= 1'b0;
      grant_id_out   <= '0;
      sd_addr_out    <= '0;
      ack_out        <= '0;
      done_out       <= '0;
      error_out      <= '0;
      busy_out       <= 1'b0;
      sd_read_en_out <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (pick_valid) grant_id_out <= pick_id;
        GRANT: begin
          sd_addr_out <= addr_in[int'(grant_id_out)*SECTOR_ADDR_W +: SECTOR_ADDR_W];
          retry_cnt   <= '0;
          retry_pend  <= 1'b0;
          ptr         <= ID_W'((int'(grant_id_out) + 1) % NUM_REQ);
        end
        ISSUE: tmo_cnt <= '0;
        WAIT:  tmo_cnt <= tmo_cnt + TO_W'(1);
        RETRY: begin
          retry_cnt  <= retry_cnt + RC_W'(1);
          retry_pend <= 1'b1;
          gap_cnt    <= '0;
        end
        RESP: gap_cnt <= '0;
        GAP: begin
          gap_cnt <= gap_cnt + GP_W'(1);
          if (gap_last) retry_pend <= 1'b0;
        end
        default: ;
      endcase

      // Outputs are registered so each pulse lines up with the state it belongs to.
      ack_out        <= (state == IDLE && pick_valid) ? onehot(pick_id) : '0;
      done_out       <= (state == WAIT && !fail && sd_done_in) ? onehot(grant_id_out) : '0;
      error_out      <= (state == WAIT && fail && !retry_left) ? onehot(grant_id_out) : '0;
      sd_read_en_out <= (state_nxt == ISSUE);
      busy_out       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Directed bench for sd_read_arbiter with a behavioural sd_access engine model
// and a per-cycle monitor that tallies pulses, grant order and read_en spacing.
module tb_sd_read_arbiter;

  localparam int NR      = 4;
  localparam int TMO     = 100;
  localparam int RETRIES = 2;
  localparam int GAPC    = 4;
  localparam int K_DONE = 0, K_ERR = 1, K_BOTH = 2, K_NONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NR-1:0] req_in = '0;
  logic [32*NR-1:0] addr_in = '0;
  logic [NR-1:0] ack_out, done_out, error_out;
  logic          busy_out;
  logic [1:0]    grant_id_out;
  logic [31:0]   sd_addr_out;
  logic          sd_read_en_out;
  logic          sd_done_in, sd_error_in;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int ack_cnt[NR], done_cnt[NR], err_cnt[NR];
  int ren_cnt, b2b, multi_pulse, min_gap, last_ren_cyc;
  int last_done_cyc, last_err_cyc, last_busy_cyc;
  logic [31:0] ren_addr;
  bit  prev_ren = 1'b0;
  int  grant_q[$];

  int resp_kind[4];
  int eng_idx = 0;
  int eng_lat = 2;

  sd_read_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRIES    (RETRIES),
    .GAP_CYCLES     (GAPC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_in         (req_in),
    .addr_in        (addr_in),
    .ack_out        (ack_out),
    .done_out       (done_out),
    .error_out      (error_out),
    .busy_out       (busy_out),
    .grant_id_out   (grant_id_out),
    .sd_addr_out    (sd_addr_out),
    .sd_read_en_out (sd_read_en_out),
    .sd_done_in     (sd_done_in),
    .sd_error_in    (sd_error_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < NR; i++) begin
      ack_cnt[i] = 0; done_cnt[i] = 0; err_cnt[i] = 0;
    end
    ren_cnt = 0; b2b = 0; multi_pulse = 0; min_gap = 1000000; last_ren_cyc = -1;
    last_done_cyc = -1; last_err_cyc = -1; last_busy_cyc = -1;
    ren_addr = '0; eng_idx = 0;
    grant_q.delete();
  endtask

  task automatic set_engine(input int lat, input int k0, input int k1, input int k2);
    eng_lat = lat;
    resp_kind[0] = k0; resp_kind[1] = k1; resp_kind[2] = k2; resp_kind[3] = K_DONE;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic request(input int id, input logic [31:0] a, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    addr_in[id*32 +: 32] = a;
    req_in[id] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_out[id] && n < 40);
    chk({tag, " ack"}, ack_out[id], 1'b1);
    req_in[id] = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    bit seen;
    n = 0;
    seen = busy_out;
    while (n < budget && !(seen && !busy_out)) begin
      @(negedge clk);
      if (busy_out) seen = 1'b1;
      n++;
    end
    chk({tag, " back to idle"}, seen && !busy_out, 1'b1);
  endtask

  function automatic int sum(input int a[NR]);
    int s;
    s = 0;
    for (int i = 0; i < NR; i++) s += a[i];
    return s;
  endfunction

  // Engine model: answers each read_en after eng_lat cycles with the scripted response.
  initial begin
    int kind;
    sd_done_in  = 1'b0;
    sd_error_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (sd_read_en_out) begin
        kind = (eng_idx < 4) ? resp_kind[eng_idx] : K_DONE;
        eng_idx++;
        if (kind != K_NONE) begin
          repeat (eng_lat - 1) @(posedge clk);
          #1;
          sd_done_in  = (kind == K_DONE || kind == K_BOTH);
          sd_error_in = (kind == K_ERR  || kind == K_BOTH);
          @(posedge clk); #1;
          sd_done_in  = 1'b0;
          sd_error_in = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (|ack_out) grant_q.push_back(int'(grant_id_out));
      for (int i = 0; i < NR; i++) begin
        ack_cnt[i]  += int'(ack_out[i]);
        done_cnt[i] += int'(done_out[i]);
        err_cnt[i]  += int'(error_out[i]);
      end
      if ($countones({ack_out, done_out, error_out}) > 1) multi_pulse++;
      if (sd_read_en_out) begin
        if (prev_ren) b2b++;
        if (last_ren_cyc >= 0 && cyc - last_ren_cyc - 1 < min_gap) min_gap = cyc - last_ren_cyc - 1;
        last_ren_cyc = cyc;
        ren_cnt++;
        ren_addr = sd_addr_out;
      end
      prev_ren = sd_read_en_out;
      if (|done_out)  last_done_cyc = cyc;
      if (|error_out) last_err_cyc  = cyc;
      if (busy_out)   last_busy_cyc = cyc;
    end
  end

  initial begin
    clear_stats();
    set_engine(2, K_DONE, K_DONE, K_DONE);
    #1 rst = 1'b1;
    #1;
    chk("reset ack",      ack_out, '0);
    chk("reset done",     done_out, '0);
    chk("reset error",    error_out, '0);
    chk("reset busy",     busy_out, 1'b0);
    chk("reset grant_id", grant_id_out, '0);
    chk("reset sd_addr",  sd_addr_out, '0);
    chk("reset read_en",  sd_read_en_out, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_stats();

    // T1: single read, engine done after 50 cycles
    set_engine(50, K_DONE, K_DONE, K_DONE);
    request(0, 32'h10, "t1");
    wait_idle("t1", 200);
    chk("t1 ack count",     ack_cnt[0], 1);
    chk("t1 read_en count", ren_cnt, 1);
    chk("t1 sd_addr",       ren_addr, 32'h10);
    chk("t1 done count",    done_cnt[0], 1);
    chk("t1 no error",      sum(err_cnt), 0);
    chk("t1 done latency",  last_done_cyc - last_ren_cyc, 50);
    chk("t1 busy fall",     last_busy_cyc - last_done_cyc, GAPC);
    chk("t1 addr held",     sd_addr_out, 32'h10);

    // T2: all four requesting continuously
    do_reset();
    set_engine(5, K_DONE, K_DONE, K_DONE);
    @(negedge clk);
    addr_in = {32'h300, 32'h200, 32'h100, 32'h000};
    req_in  = 4'b1111;
    begin
      int n;
      n = 0;
      while (sum(done_cnt) < 5 && n < 300) begin
        @(negedge clk);
        n++;
      end
    end
    req_in = '0;
    wait_idle("t2", 100);
    chk("t2 grants", grant_q.size(), 5);
    for (int i = 0; i < 5 && i < grant_q.size(); i++)
      chk($sformatf("t2 grant[%0d]", i), grant_q[i], i % NR);
    chk("t2 acks equal dones", sum(ack_cnt), sum(done_cnt));
    chk("t2 read_en spacing",  min_gap, 11);
    chk("t2 read_en b2b",      b2b, 0);
    chk("t2 single pulse",     multi_pulse, 0);
    chk("t2 last addr",        ren_addr, 32'h000);

    // T3: error, error, done on requester 2
    do_reset();
    set_engine(10, K_ERR, K_ERR, K_DONE);
    request(2, 32'h2222_0000, "t3");
    wait_idle("t3", 300);
    chk("t3 read_en count", ren_cnt, 3);
    chk("t3 one ack",       sum(ack_cnt), 1);
    chk("t3 done[2]",       done_cnt[2], 1);
    chk("t3 done total",    sum(done_cnt), 1);
    chk("t3 no error",      sum(err_cnt), 0);
    chk("t3 retry addr",    ren_addr, 32'h2222_0000);
    chk("t3 retry spacing", min_gap, 14);

    // T4: engine silent, every attempt times out
    do_reset();
    set_engine(2, K_NONE, K_NONE, K_NONE);
    request(1, 32'hABC, "t4");
    wait_idle("t4", 600);
    chk("t4 read_en count", ren_cnt, 3);
    chk("t4 error[1]",      err_cnt[1], 1);
    chk("t4 no done",       sum(done_cnt), 0);
    chk("t4 error latency", last_err_cyc - last_ren_cyc, TMO + 1);

    // T5: done and error together, then spurious engine strobes while idle
    do_reset();
    set_engine(3, K_BOTH, K_BOTH, K_BOTH);
    request(3, 32'h33, "t5");
    wait_idle("t5", 200);
    chk("t5 error[3]",      err_cnt[3], 1);
    chk("t5 no done",       sum(done_cnt), 0);
    chk("t5 read_en count", ren_cnt, 3);
    last_busy_cyc = -1;
    @(negedge clk);
    sd_done_in = 1'b1;
    @(negedge clk);
    sd_done_in  = 1'b0;
    sd_error_in = 1'b1;
    @(negedge clk);
    sd_error_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5 spurious done",  sum(done_cnt), 0);
    chk("t5 spurious error", sum(err_cnt), 1);
    chk("t5 spurious busy",  last_busy_cyc, -1);

    // T6: reset in WAIT, then pointer must restart at 0
    do_reset();
    set_engine(2, K_NONE, K_NONE, K_NONE);
    request(1, 32'h55, "t6");
    repeat (6) @(negedge clk);
    chk("t6 busy before rst", busy_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6 rst ack",      ack_out, '0);
    chk("t6 rst done",     done_out, '0);
    chk("t6 rst error",    error_out, '0);
    chk("t6 rst busy",     busy_out, 1'b0);
    chk("t6 rst grant_id", grant_id_out, '0);
    chk("t6 rst sd_addr",  sd_addr_out, '0);
    chk("t6 rst read_en",  sd_read_en_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    set_engine(4, K_DONE, K_DONE, K_DONE);
    @(negedge clk);
    addr_in[1*32 +: 32] = 32'h111;
    addr_in[3*32 +: 32] = 32'h333;
    req_in = 4'b1010;
    begin
      int n;
      n = 0;
      while (!(|ack_out) && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t6 first grant id", grant_id_out, 2'd1);
    chk("t6 first ack",      ack_out, 4'b0010);
    req_in[1] = 1'b0;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ack_out[3] && n < 60);
    end
    chk("t6 ack[3]",    ack_out, 4'b1000);
    chk("t6 grant id 3", grant_id_out, 2'd3);
    req_in[3] = 1'b0;
    wait_idle("t6", 100);
    chk("t6 done count", sum(done_cnt), 2);
    chk("t6 last addr",  sd_addr_out, 32'h333);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
